// File: rtl/if_stage_pkg.sv
// Shared constants, FSM state type and word-assembly helper for the instruction-fetch stage.
package if_stage_pkg;

    localparam int ADDR_LEN       = 32;
    localparam int INST_LEN       = 32;
    localparam int ICACHE_IDX_LEN = 7;

    localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // Instruction memory is little-endian: the last byte fetched is the top byte.
    function automatic logic [INST_LEN-1:0] assemble_word(input logic [23:0] low_bytes,
                                                          input logic [7:0]  top_byte);
        return {top_byte, low_bytes};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Byte-wide request/response bus between the fetch stage and the memory controller.
interface if_stage_if #(
    parameter int ADDR_W = if_stage_pkg::ADDR_LEN
);
    logic              if_mem_req;
    logic [ADDR_W-1:0] if_mem_addr;
    logic              mem_if_valid;
    logic [7:0]        mem_if_data;

    modport master (
        output if_mem_req,
        output if_mem_addr,
        input  mem_if_valid,
        input  mem_if_data
    );

    modport slave (
        input  if_mem_req,
        input  if_mem_addr,
        output mem_if_valid,
        output mem_if_data
    );
endinterface

// File: rtl/if_stage_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, clocked fill.
module icache
    import if_stage_pkg::*;
#(
    parameter int IDX_W = ICACHE_IDX_LEN,
    parameter int TAG_W = ADDR_LEN - ICACHE_IDX_LEN - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    rd_idx,
    input  logic [TAG_W-1:0]    rd_tag,
    output logic                hit,
    output logic [INST_LEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [INST_LEN-1:0] wr_data
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]    line_valid;
    logic [TAG_W-1:0]    tags  [DEPTH];
    logic [INST_LEN-1:0] words [DEPTH];

    assign hit     = line_valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_data = words[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
        end else if (wr_en) begin
            line_valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            words[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: cache lookup on each new pc, four-byte refill on miss, IF/ID hand-off.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int ICACHE_IDX_W = ICACHE_IDX_LEN,
    parameter int ADDR_W       = ADDR_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                pc_reg_rdy,
    output logic                pc_reg_stall,
    input  logic                jump_or_not,
    input  logic                id_stall,
    if_stage_if.master          mem,
    output logic                if_valid,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [INST_LEN-1:0] if_inst
);
    localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

    fetch_state_t state, state_nxt;

    logic [1:0]          k, k_nxt;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nxt;
    logic [23:0]         byte_buf, byte_buf_nxt;
    logic                valid_nxt;
    logic [ADDR_W-1:0]   pc_out_nxt;
    logic [INST_LEN-1:0] inst_nxt;
    logic                req_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                fill_done;
    logic                cache_we;
    logic                hit;
    logic [INST_LEN-1:0] hit_data;

    icache #(
        .IDX_W (ICACHE_IDX_W),
        .TAG_W (TAG_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (pc[ICACHE_IDX_W+1:2]),
        .rd_tag  (pc[ADDR_W-1:ICACHE_IDX_W+2]),
        .hit     (hit),
        .rd_data (hit_data),
        .wr_en   (cache_we),
        .wr_idx  (fetch_pc[ICACHE_IDX_W+1:2]),
        .wr_tag  (fetch_pc[ADDR_W-1:ICACHE_IDX_W+2]),
        .wr_data (inst_nxt)
    );

    assign fill_done    = (state == ST_FETCH) && mem.mem_if_valid && (k == 2'd3);
    // A flushed or frozen cycle must never commit a partial or stale line.
    assign cache_we     = fill_done && !jump_or_not && rdy && !rst;
    assign pc_reg_stall = (state != ST_IDLE) | (pc_reg_rdy & ~hit) | id_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (jump_or_not) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pc_reg_rdy) begin
                        if (!hit) begin
                            state_nxt = ST_FETCH;
                        end else if (id_stall) begin
                            state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_FETCH: begin
                    if (fill_done) begin
                        state_nxt = id_stall ? ST_HOLD : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!id_stall) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        k_nxt        = k;
        fetch_pc_nxt = fetch_pc;
        byte_buf_nxt = byte_buf;
        valid_nxt    = 1'b0;
        pc_out_nxt   = if_pc;
        inst_nxt     = if_inst;
        req_nxt      = mem.if_mem_req;
        addr_nxt     = mem.if_mem_addr;
        if (jump_or_not) begin
            k_nxt   = 2'd0;
            req_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pc_reg_rdy) begin
                        if (hit) begin
                            valid_nxt  = 1'b1;
                            pc_out_nxt = pc;
                            inst_nxt   = hit_data;
                        end else begin
                            fetch_pc_nxt = pc;
                            k_nxt        = 2'd0;
                            req_nxt      = 1'b1;
                            addr_nxt     = pc;
                        end
                    end
                end
                ST_FETCH: begin
                    if (mem.mem_if_valid) begin
                        if (k == 2'd3) begin
                            valid_nxt  = 1'b1;
                            pc_out_nxt = fetch_pc;
                            inst_nxt   = assemble_word(byte_buf, mem.mem_if_data);
                            req_nxt    = 1'b0;
                            k_nxt      = 2'd0;
                        end else begin
                            case (k)
                                2'd0:    byte_buf_nxt[7:0]   = mem.mem_if_data;
                                2'd1:    byte_buf_nxt[15:8]  = mem.mem_if_data;
                                default: byte_buf_nxt[23:16] = mem.mem_if_data;
                            endcase
                            k_nxt    = k + 2'd1;
                            addr_nxt = fetch_pc + ADDR_W'(k) + ADDR_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    valid_nxt = id_stall;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k               <= 2'd0;
            fetch_pc        <= '0;
            byte_buf        <= '0;
            if_valid        <= 1'b0;
            if_pc           <= '0;
            if_inst         <= ZERO_WORD;
            mem.if_mem_req  <= 1'b0;
            mem.if_mem_addr <= '0;
        end else if (rdy) begin
            k               <= k_nxt;
            fetch_pc        <= fetch_pc_nxt;
            byte_buf        <= byte_buf_nxt;
            if_valid        <= valid_nxt;
            if_pc           <= pc_out_nxt;
            if_inst         <= inst_nxt;
            mem.if_mem_req  <= req_nxt;
            mem.if_mem_addr <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a byte memory that answers one cycle after each request.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] pc = '0;
    logic        pc_reg_rdy = 1'b0;
    logic        pc_reg_stall;
    logic        jump_or_not = 1'b0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;

    if_stage_if #(.ADDR_W(32)) mem_bus ();

    if_stage #(
        .ICACHE_IDX_W (7),
        .ADDR_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .pc           (pc),
        .pc_reg_rdy   (pc_reg_rdy),
        .pc_reg_stall (pc_reg_stall),
        .jump_or_not  (jump_or_not),
        .id_stall     (id_stall),
        .mem          (mem_bus),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h000: return 8'h13;
            32'h001: return 8'h05;
            32'h002: return 8'h00;
            32'h003: return 8'h00;
            32'h200: return 8'h93;
            32'h201: return 8'h00;
            32'h202: return 8'h10;
            32'h203: return 8'h00;
            32'h010: return 8'hb7;
            32'h011: return 8'h12;
            32'h012: return 8'h34;
            32'h013: return 8'h56;
            default: return a[7:0] ^ 8'h5a;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory answers a pending request on the following cycle, then idles for one cycle.
    task automatic tick();
        logic nv;
        nv = mem_bus.if_mem_req && !mem_bus.mem_if_valid;
        @(posedge clk);
        #1;
        mem_bus.mem_if_valid = nv;
        mem_bus.mem_if_data  = mem_byte(mem_bus.if_mem_addr);
    endtask

    task automatic start_miss(input logic [31:0] base);
        pc = base;
        pc_reg_rdy = 1'b1;
        #1;
        check("miss_stall", pc_reg_stall, 1'b1);
        tick();
        pc_reg_rdy = 1'b0;
    endtask

    task automatic feed_bytes(input logic [31:0] base, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            check("fetch_req", mem_bus.if_mem_req, 1'b1);
            check("fetch_addr", mem_bus.if_mem_addr, base + 32'(i));
            tick();
            tick();
        end
    endtask

    task automatic finish_miss(input logic [31:0] base, input logic [31:0] word);
        check("fill_valid", if_valid, 1'b1);
        check("fill_inst", if_inst, word);
        check("fill_pc", if_pc, base);
        check("fill_req_off", mem_bus.if_mem_req, 1'b0);
        tick();
        check("fill_valid_drop", if_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        mem_bus.mem_if_valid = 1'b0;
        mem_bus.mem_if_data  = 8'h00;

        // reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid", if_valid, 1'b0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_req", mem_bus.if_mem_req, 1'b0);
        check("rst_addr", mem_bus.if_mem_addr, 32'h0);
        check("rst_stall", pc_reg_stall, 1'b0);

        // cold miss at 0x0
        start_miss(32'h0);
        feed_bytes(32'h0, 0, 3);
        finish_miss(32'h0, 32'h00000513);

        // refetch 0x0 hits, two back-to-back
        pc = 32'h0;
        pc_reg_rdy = 1'b1;
        #1;
        check("hit_stall", pc_reg_stall, 1'b0);
        tick();
        check("hit_valid", if_valid, 1'b1);
        check("hit_inst", if_inst, 32'h00000513);
        check("hit_req", mem_bus.if_mem_req, 1'b0);
        tick();
        check("hit2_valid", if_valid, 1'b1);
        pc_reg_rdy = 1'b0;
        tick();
        check("hit_valid_drop", if_valid, 1'b0);

        // rdy low freezes outputs
        pc_reg_rdy = 1'b1;
        tick();
        pc_reg_rdy = 1'b0;
        rdy = 1'b0;
        tick();
        check("frz_valid1", if_valid, 1'b1);
        tick();
        check("frz_valid2", if_valid, 1'b1);
        rdy = 1'b1;
        tick();
        check("frz_release", if_valid, 1'b0);

        // conflict miss at 0x200 evicts 0x0
        start_miss(32'h200);
        feed_bytes(32'h200, 0, 3);
        finish_miss(32'h200, 32'h00100093);
        start_miss(32'h0);
        feed_bytes(32'h0, 0, 3);
        finish_miss(32'h0, 32'h00000513);

        // flush after two bytes of a miss at 0x10
        start_miss(32'h10);
        feed_bytes(32'h10, 0, 1);
        jump_or_not = 1'b1;
        tick();
        jump_or_not = 1'b0;
        check("flush_req", mem_bus.if_mem_req, 1'b0);
        check("flush_valid", if_valid, 1'b0);
        tick();
        check("late_byte_valid", if_valid, 1'b0);
        check("late_byte_req", mem_bus.if_mem_req, 1'b0);
        start_miss(32'h10);
        feed_bytes(32'h10, 0, 3);
        finish_miss(32'h10, 32'h563412b7);

        // flush beats a simultaneous new pc
        pc = 32'h300;
        pc_reg_rdy = 1'b1;
        jump_or_not = 1'b1;
        tick();
        pc_reg_rdy = 1'b0;
        jump_or_not = 1'b0;
        #1;
        check("flushprio_req", mem_bus.if_mem_req, 1'b0);
        check("flushprio_stall", pc_reg_stall, 1'b0);

        // id_stall for 3 cycles around the completing byte of a miss at 0x40
        start_miss(32'h40);
        feed_bytes(32'h40, 0, 2);
        check("stall_addr3", mem_bus.if_mem_addr, 32'h43);
        tick();
        id_stall = 1'b1;
        #1;
        check("stall_pcstall0", pc_reg_stall, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("hold_valid", if_valid, 1'b1);
            check("hold_inst", if_inst, 32'h19181b1a);
            check("hold_pcstall", pc_reg_stall, 1'b1);
        end
        id_stall = 1'b0;
        #1;
        check("hold_exit_pcstall", pc_reg_stall, 1'b1);
        tick();
        check("hold_release_valid", if_valid, 1'b0);
        check("hold_release_pcstall", pc_reg_stall, 1'b0);

        // reset in the middle of a miss at 0x80
        start_miss(32'h80);
        feed_bytes(32'h80, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_req", mem_bus.if_mem_req, 1'b0);
        check("midrst_addr", mem_bus.if_mem_addr, 32'h0);
        check("midrst_valid", if_valid, 1'b0);
        pc = 32'h0;
        pc_reg_rdy = 1'b1;
        #1;
        check("midrst_cache_cleared", pc_reg_stall, 1'b1);
        pc_reg_rdy = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage sitting directly downstream of the PC register. It takes each new `pc` announced by `pc_reg_rdy`, looks it up in a small direct-mapped instruction cache, and on a miss assembles the 32-bit instruction from four byte reads through the memory controller. It then presents `{pc, inst}` to the IF/ID latch, holds the PC register via `pc_reg_stall` while busy, and discards all in-flight work on a taken jump.

## Interface
Parameters:
- `ICACHE_IDX_W`, default 7: cache index width, giving 2^7 = 128 entries of one word each.
- `ADDR_W`, default `` `AddrLen `` (32): address width.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rdy`  in  1: global ready. When low the block freezes all state and outputs.
- `pc`  in  ADDR_W: fetch address from the PC register.
- `pc_reg_rdy`  in  1: `pc` is new and valid this cycle.
- `pc_reg_stall`  out  1: combinational; holds the PC register.
- `jump_or_not`  in  1: taken jump/branch; flushes the block.
- `id_stall`  in  1: IF/ID cannot accept a new instruction.
- `if_mem_req`  out  1: level request to the memory controller.
- `if_mem_addr`  out  ADDR_W: byte address requested.
- `mem_if_valid`  in  1: `mem_if_data` carries the byte for `if_mem_addr`.
- `mem_if_data`  in  8: returned byte.
- `if_valid`  out  1: `if_pc`/`if_inst` are valid.
- `if_pc`  out  ADDR_W: PC of the presented instruction.
- `if_inst`  out  32: presented instruction, little-endian assembled.

## Operation
- Address split: index = `pc[ICACHE_IDX_W+1:2]`; tag = `pc[ADDR_W-1:ICACHE_IDX_W+2]`. `pc[1:0]` is always 0.
- Cache entry = {valid, tag, 32-bit data}. All valid bits are cleared on reset. The cache is never invalidated otherwise; instruction memory is read-only.
- FSM states are IDLE, FETCH and HOLD.
- **IDLE**, when `pc_reg_rdy`=1:
  - Hit: the next cycle has `if_valid`=1 with the cached word. Stay in IDLE.
  - Miss: latch `pc` into `fetch_pc` and set byte counter k=0. Go to FETCH.
- **FETCH**:
  - `if_mem_req`=1 and `if_mem_addr`=`fetch_pc`+k.
  - On `mem_if_valid`, store the byte into bits [8k+7:8k] and increment k.
  - When k=3 is received: write the cache entry, drive `if_valid`=1 with the assembled word on the next cycle, and go to IDLE. If `id_stall`=1 at that point, go to HOLD instead.
- **HOLD**: output registers are frozen with `if_valid` held at 1. Return to IDLE when `id_stall`=0.
- In IDLE, a hit while `id_stall`=1 also enters HOLD, with the hit word captured.
- `if_valid` drops to 0 in any cycle with no newly produced instruction and no HOLD.
- `pc_reg_stall` = (state≠IDLE) | (`pc_reg_rdy` & miss) | `id_stall`.
- Flush, when `jump_or_not`=1:
  - Next state is IDLE; k resets to 0; `if_valid` is 0 on the next cycle; `if_mem_req` is 0 on the next cycle.
  - A `mem_if_valid` byte arriving after the flush is ignored.
  - A partially fetched word is never written to the cache.
  - Flush has priority over every other event in the same cycle, including `pc_reg_rdy`.
- `rdy`=0 freezes the FSM, the counter, the cache and all outputs. `if_mem_req` keeps its value.

## Timing
- Reset values: `if_valid`=0, `if_pc`=0, `if_inst`=0, `if_mem_req`=0, `if_mem_addr`=0, state=IDLE, k=0, all cache valid bits=0.
- Hit latency: `pc_reg_rdy` in cycle N gives `if_valid` in cycle N+1. Back-to-back hits sustain 1 instruction per cycle.
- Miss latency: 1 cycle to enter FETCH, plus the 4 byte returns, plus 1 output cycle. With a 1-cycle memory this is 6 cycles.
- Memory handshake: the controller may return `mem_if_valid` no earlier than the cycle after it sees the request. The address advances in the cycle after each valid byte.
- Reset in mid-FETCH: everything returns to reset values on the next edge. No cache write occurs.

## Structure
- `` `AddrLen ``, `` `InstLen ``, `` `ZERO_WORD ``, `` `True ``/`` `False `` and the new `` `ICacheIdxLen `` belong in the shared `config.v`. FSM state encodings are local parameters.
- One sub-module, `icache`, holds the valid/tag/data arrays.
  - Combinational read port returning hit and data.
  - Synchronous write port; write takes effect at the clock edge.
  - Reset clears the valid bits.

## Test plan
- Reset: hold `rst` 2 cycles → every output is 0 and `pc_reg_stall`=`id_stall`.
- Cold miss at pc=0x0000, memory bytes 0x13,0x05,0x00,0x00 → `if_mem_addr` steps 0,1,2,3, then `if_inst`=0x00000513, `if_pc`=0 and `if_valid` high for 1 cycle.
- Refetch pc=0x0000 → hit, `if_valid` the next cycle, no `if_mem_req`, `pc_reg_stall`=0.
- Conflict: pc=0x0200 (same index, different tag) after 0x0000 → miss and refill. A following fetch of 0x0000 misses again.
- `jump_or_not` after 2 bytes of a miss at 0x0010 → `if_mem_req` drops, late bytes are ignored, no cache write; a later fetch of 0x0010 misses.
- `id_stall` high for 3 cycles during a completed miss → `if_valid`/`if_inst` are held for 3 cycles, then released, and `pc_reg_stall` is asserted throughout.
